// File: rtl/led_cube_uart_tx_if.sv
// Avalon-MM master bus between the cube TX sequencer and the UART core register map.
interface led_cube_uart_tx_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   logic              waitrequest;

   modport master (
      output read, write, address, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  read, write, address, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/led_cube_uart_tx.sv
// Queues bytes from a local producer and writes them to the UART TXDATA register,
// polling STATUS for TRDY before every character.
//
// state        | meaning
// ST_IDLE      | nothing in flight; leave when the FIFO holds a byte
// ST_POLL_RD   | status read request on the bus, held through waitrequest
// ST_POLL_WAIT | read accepted, waiting for readdatavalid
// ST_WRITE     | txdata write of the FIFO head, held through waitrequest
module led_cube_uart_tx #(
   parameter int FIFO_DEPTH  = 8,
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 16,
   parameter int TXDATA_ADDR = 1,
   parameter int STATUS_ADDR = 2,
   parameter int TRDY_BIT    = 6
) (
   input  logic                               clock_sink_clk,
   input  logic                               reset_sink_reset,
   input  logic [7:0]                         tx_byte,
   input  logic                               tx_valid,
   output logic                               tx_ready,
   led_cube_uart_tx_if.master                 avm,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POLL_RD,
      ST_POLL_WAIT,
      ST_WRITE
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        head;
   logic              push;
   logic              pop;
   logic              unused_readdata;

   // Only the TRDY bit of the status word matters here.
   assign unused_readdata = ^avm.readdata;

   assign head     = mem_q[rd_ptr_q];
   assign tx_ready = (count_q != CNT_W'(FIFO_DEPTH));
   assign push     = tx_valid & tx_ready;

   always_comb begin
      state_d     = state_q;
      writedata_d = writedata_q;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) state_d = ST_POLL_RD;
         end
         ST_POLL_RD: begin
            if (!avm.waitrequest) state_d = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            if (avm.readdatavalid) begin
               if (avm.readdata[TRDY_BIT]) begin
                  state_d     = ST_WRITE;
                  writedata_d = {{(DATA_W-8){1'b0}}, head};
               end else begin
                  state_d = ST_POLL_RD;
               end
            end
         end
         ST_WRITE: begin
            if (!avm.waitrequest) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
      if (!reset_sink_reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         writedata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         writedata_q <= writedata_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clock_sink_clk) begin
      if (push) mem_q[wr_ptr_q] <= tx_byte;
   end

   assign avm.read      = (state_q == ST_POLL_RD);
   assign avm.write     = (state_q == ST_WRITE);
   assign avm.address   = (state_q == ST_POLL_RD) ? ADDR_W'(STATUS_ADDR) :
                          (state_q == ST_WRITE)   ? ADDR_W'(TXDATA_ADDR) : '0;
   assign avm.writedata = writedata_q;

   assign fifo_count = count_q;
   assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule
